// File: rtl/pipeline_sequencer_if.sv
// Command/status bundle between the debug unit, hazard logic and the pipeline sequencer.
// Signal semantics: i_* are level inputs sampled every rising edge (i_step is a one-cycle pulse);
// o_* are enables/flushes valid for the current cycle, with no ready back-pressure.
interface pipeline_sequencer_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 i_run;
    logic                 i_step;
    logic                 i_halt;
    logic                 i_load_use;
    logic                 i_branch_taken;
    logic                 o_pc_enable;
    logic                 o_if_id_enable;
    logic                 o_if_id_flush;
    logic                 o_id_ex_flush;
    logic                 o_pipe_enable;
    logic                 o_halted;
    logic [CNT_WIDTH-1:0] o_cycle_count;

    modport master (
        output i_run, i_step, i_halt, i_load_use, i_branch_taken,
        input  o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_flush,
               o_pipe_enable, o_halted, o_cycle_count
    );

    modport slave (
        input  i_run, i_step, i_halt, i_load_use, i_branch_taken,
        output o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_flush,
               o_pipe_enable, o_halted, o_cycle_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline control: run/step arbitration, hazard stall/flush and halt drain.
// Enables are combinational from state and hazards so stalls act in the cycle they are raised.
module pipeline_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    pipeline_sequencer_if.slave   bus,
    output logic [2:0]            o_dbg_state
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    generate
        if (DRAIN_CYCLES < 1) begin : g_bad_drain
            $error("pipeline_sequencer: DRAIN_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t               state_q;
    logic [DW-1:0]        drain_q;
    logic [CNT_WIDTH-1:0] cycle_count_q;
    logic [CNT_WIDTH-1:0] cycle_count_d;

    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_enable;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_run) begin
                        state_q <= ST_RUN;
                    end else if (bus.i_step) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (bus.i_halt) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DW'(DRAIN_CYCLES);
                    end
                end
                ST_STEP: begin
                    if (bus.i_halt) begin
                        state_q <= ST_DRAIN;
                        drain_q <= DW'(DRAIN_CYCLES);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Counter holds the number of drain cycles still to run, including this one.
                    if (drain_q == DW'(1)) begin
                        state_q <= ST_HALTED;
                        drain_q <= '0;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_IDLE;
                    drain_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_enable  = 1'b0;
        case (state_q)
            ST_RUN, ST_STEP: begin
                pipe_enable = 1'b1;
                if (bus.i_halt) begin
                    // HALT moves on into ID_EX; the instruction fetched behind it is squashed.
                    if_id_flush = 1'b1;
                end else if (bus.i_load_use) begin
                    id_ex_flush = 1'b1;
                end else if (bus.i_branch_taken) begin
                    pc_enable    = 1'b1;
                    if_id_enable = 1'b1;
                    if_id_flush  = 1'b1;
                end else begin
                    pc_enable    = 1'b1;
                    if_id_enable = 1'b1;
                end
            end
            ST_DRAIN: begin
                pipe_enable = 1'b1;
            end
            default: begin
                pipe_enable = 1'b0;
            end
        endcase
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (pipe_enable) begin
            cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.o_pc_enable    = pc_enable;
    assign bus.o_if_id_enable = if_id_enable;
    assign bus.o_if_id_flush  = if_id_flush;
    assign bus.o_id_ex_flush  = id_ex_flush;
    assign bus.o_pipe_enable  = pipe_enable;
    assign bus.o_halted       = (state_q == ST_HALTED);
    assign bus.o_cycle_count  = cycle_count_q;
    assign o_dbg_state        = state_q;

endmodule
